// File: rtl/cymo_pkg.sv
// ============================================================================
// cymo_pkg : shared types and default timing for the cymometer fx front end
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package cymo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_OPEN = 3'd2,
        ST_POST = 3'd3,
        ST_PUB  = 3'd4,
        ST_REL  = 3'd5
    } fx_state_t;

    localparam int PRE_TIME_DEF    = 10;
    localparam int POST_TIME_DEF   = 10;
    localparam int CNT_W_DEF       = 32;
    localparam int ACK_TIMEOUT_DEF = 1024;
    localparam int MEAS_ID_W       = 4;

    // A zero-length gate would never close, so it is promoted to one cycle.
    function automatic logic [15:0] norm_gate_len(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop single-bit synchroniser, async active-low reset
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fx_gate_ctrl.sv
// ============================================================================
// fx_gate_ctrl : clk_fx gate generator, fx counter and req/ack result handoff
// Optional macro FX_ACK_TIMEOUT_EN adds a PUB-state ack timeout.
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module fx_gate_ctrl
    import cymo_pkg::*;
#(
    parameter int PRE_TIME    = PRE_TIME_DEF,
    parameter int POST_TIME   = POST_TIME_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                 clk_fx,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [15:0]          gate_len,
    output logic                 gate_fx,
    output logic [CNT_W-1:0]     fx_cnt,
    output logic                 cnt_req,
    input  logic                 cnt_ack,
    output logic [MEAS_ID_W-1:0] meas_id,
    output logic                 busy,
    output logic                 ack_timeout
);

    localparam logic [15:0] PRE_LAST  = 16'(PRE_TIME - 1);
    localparam logic [15:0] POST_LAST = 16'(POST_TIME - 1);

    if (PRE_TIME < 1 || POST_TIME < 1 || ACK_TIMEOUT < 1 || CNT_W < 16) begin : g_bad_params
        $error("fx_gate_ctrl: invalid parameter set");
    end

    logic run_s;
    logic ack_s;

    sync_2ff u_sync_run (
        .clk   (clk_fx),
        .rst_n (rst_n),
        .d     (run),
        .q     (run_s)
    );

    sync_2ff u_sync_ack (
        .clk   (clk_fx),
        .rst_n (rst_n),
        .d     (cnt_ack),
        .q     (ack_s)
    );

    fx_state_t        state;
    logic [15:0]      phase;
    logic [15:0]      len_q;
    logic [CNT_W-1:0] acc;
    logic             ack_low_seen;

`ifdef FX_ACK_TIMEOUT_EN
    localparam int             TO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign ack_timeout = 1'b0;
`endif

    always_ff @(posedge clk_fx or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            phase        <= '0;
            len_q        <= 16'd1;
            acc          <= '0;
            gate_fx      <= 1'b0;
            fx_cnt       <= '0;
            cnt_req      <= 1'b0;
            meas_id      <= '0;
            busy         <= 1'b0;
            ack_low_seen <= 1'b0;
`ifdef FX_ACK_TIMEOUT_EN
            to_cnt       <= '0;
            ack_timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    len_q <= norm_gate_len(gate_len);
                    phase <= '0;
                    acc   <= '0;
                    if (run_s) begin
                        state <= ST_PRE;
                        busy  <= 1'b1;
                    end
                end

                ST_PRE: begin
                    if (phase == PRE_LAST) begin
                        phase   <= '0;
                        gate_fx <= 1'b1;
                        state   <= ST_OPEN;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end

                ST_OPEN: begin
                    if (gate_fx) begin
                        acc <= acc + CNT_W'(1);
                    end
                    // fx_cnt takes the value the accumulator reaches on this same edge.
                    if (phase == len_q - 16'd1) begin
                        phase   <= '0;
                        gate_fx <= 1'b0;
                        fx_cnt  <= acc + CNT_W'(1);
                        state   <= ST_POST;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end

                ST_POST: begin
                    if (phase == POST_LAST) begin
                        phase        <= '0;
                        cnt_req      <= 1'b1;
                        ack_low_seen <= 1'b0;
`ifdef FX_ACK_TIMEOUT_EN
                        to_cnt       <= '0;
`endif
                        state        <= ST_PUB;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end

                ST_PUB: begin
                    // A stale high ack must be seen low before a rising ack counts.
                    if (!ack_s) begin
                        ack_low_seen <= 1'b1;
                    end
                    if (ack_s && ack_low_seen) begin
                        cnt_req <= 1'b0;
                        state   <= ST_REL;
                    end
`ifdef FX_ACK_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        cnt_req     <= 1'b0;
                        ack_timeout <= 1'b1;
                        state       <= ST_REL;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end

                ST_REL: begin
                    if (!ack_s) begin
                        meas_id <= meas_id + MEAS_ID_W'(1);
                        if (run_s) begin
                            len_q <= norm_gate_len(gate_len);
                            phase <= '0;
                            acc   <= '0;
                            state <= ST_PRE;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
